// File: rtl/fa_bist_checker.sv
// Built-in self-test controller for a 1-bit full adder: walks all eight {a,b,cin}
// vectors, samples the adder on the last hold cycle and reports count/first-fail/pass.
module fa_bist_checker #(
    parameter int HOLD_CYCLES = 50,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sum_in,
    input  logic             c_out_in,
    output logic             a_out,
    output logic             b_out,
    output logic             cin_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       first_fail,
    output logic             fail_valid
);

    localparam int                HC_W      = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic golden_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic golden_cout(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       ff_q, ff_d;
    logic             fv_q, fv_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mismatch_s;

    // Next-state logic: start handling, hold counting and per-vector comparison
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        hold_d     = hold_q;
        err_d      = err_q;
        ff_d       = ff_q;
        fv_d       = fv_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = done_q;
        mismatch_s = (sum_in != golden_sum(vec_q)) || (c_out_in != golden_cout(vec_q));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    vec_d   = 3'd0;
                    hold_d  = '0;
                    err_d   = '0;
                    ff_d    = 3'd0;
                    fv_d    = 1'b0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                hold_d = hold_q + HC_W'(1);
                if (hold_q == HOLD_LAST) begin
                    // Both bits wrong still counts as a single mismatch
                    if (mismatch_s) begin
                        err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
                        if (!fv_q) begin
                            ff_d = vec_q;
                            fv_d = 1'b1;
                        end else begin
                            ff_d = ff_q;
                        end
                    end else begin
                        err_d = err_q;
                    end
                    hold_d = '0;
                    if (vec_q != 3'd7) begin
                        vec_d = vec_q + 3'd1;
                    end else begin
                        state_d = ST_DONE;
                        vec_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = !(fv_q || mismatch_s);
                    end
                end else begin
                    vec_d = vec_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vec_d   = 3'd0;
                hold_d  = '0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 3'd0;
            hold_q  <= '0;
            err_q   <= '0;
            ff_q    <= 3'd0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out      = vec_q[2];
    assign b_out      = vec_q[1];
    assign cin_out    = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_cnt    = err_q;
    assign first_fail = ff_q;
    assign fail_valid = fv_q;

endmodule

// File: tb/tb_fa_bist_checker.sv
// Scoreboard bench for fa_bist_checker with a behavioural adder that can be
// switched between correct, sum-stuck-at-0 and inverted-carry behaviour.
module tb_fa_bist_checker;

    localparam int HOLD  = 4;
    localparam int EW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sum_in, c_out_in;
    logic          a_out, b_out, cin_out, busy, done, pass, fail_valid;
    logic [EW-1:0] err_cnt;
    logic [2:0]    first_fail;
    int            mode = 0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int err;
        int ff;
        int fv;
        int ps;
        int busy_len;
    } exp_t;

    exp_t exp_q[$];

    fa_bist_checker #(.HOLD_CYCLES(HOLD), .ERR_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sum_in(sum_in), .c_out_in(c_out_in),
        .a_out(a_out), .b_out(b_out), .cin_out(cin_out),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .first_fail(first_fail), .fail_valid(fail_valid)
    );

    always #5 clk = ~clk;

    // Adder under test: 0 correct, 1 sum stuck at 0, 2 carry inverted
    always_comb begin
        sum_in   = a_out ^ b_out ^ cin_out;
        c_out_in = (a_out & b_out) | (a_out & cin_out) | (b_out & cin_out);
        if (mode == 1) sum_in = 1'b0;
        else if (mode == 2) c_out_in = ~((a_out & b_out) | (a_out & cin_out) | (b_out & cin_out));
        else sum_in = a_out ^ b_out ^ cin_out;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vec"},   int'({a_out, b_out, cin_out}), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_pass"},  int'(pass), 0);
        chk({tag, "_err"},   int'(err_cnt), 0);
        chk({tag, "_ff"},    int'(first_fail), 0);
        chk({tag, "_fv"},    int'(fail_valid), 0);
    endtask

    task automatic push_exp(input int err, input int ff, input int fv, input int ps);
        exp_t e;
        e.err = err; e.ff = ff; e.fv = fv; e.ps = ps; e.busy_len = 8 * HOLD;
        exp_q.push_back(e);
    endtask

    task automatic start_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    // Monitor: checks the vector walk each busy cycle, pops a result on done rise
    initial begin
        int   cnt;
        logic done_prev;
        exp_t e;
        cnt = 0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
                done_prev = 1'b0;
            end else begin
                if (busy) begin
                    chk("vec_step", int'({a_out, b_out, cin_out}), cnt / HOLD);
                    cnt++;
                end
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_len",   cnt, e.busy_len);
                        chk("err_cnt",    int'(err_cnt), e.err);
                        chk("first_fail", int'(first_fail), e.ff);
                        chk("fail_valid", int'(fail_valid), e.fv);
                        chk("pass",       int'(pass), e.ps);
                        chk("done_vec",   int'({a_out, b_out, cin_out}), 0);
                    end
                    cnt = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        #1 chk_all_zero("por");
        #20 rst_n = 1'b1;

        mode = 0;
        push_exp(0, 0, 0, 1);
        start_run();
        chk("e0_busy", int'(busy), 1);
        wait_done();

        mode = 1;
        push_exp(4, 1, 1, 0);
        start_run();
        wait_done();

        // Restart from DONE with a good adder: results clear on the start edge
        mode = 0;
        push_exp(0, 0, 0, 1);
        start_run();
        chk("rs_done", int'(done), 0);
        chk("rs_err",  int'(err_cnt), 0);
        chk("rs_fv",   int'(fail_valid), 0);
        chk("rs_pass", int'(pass), 0);
        chk("rs_busy", int'(busy), 1);
        wait_done();

        mode = 2;
        push_exp(7, 0, 1, 0);
        start_run();
        wait_done();

        // Start pulse at vector 3 must be ignored
        mode = 0;
        push_exp(0, 0, 0, 1);
        start_run();
        repeat (13) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();

        // Reset during vector 5 aborts the run
        start_run();
        repeat (21) @(posedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk_all_zero("post_rst");

        push_exp(0, 0, 0, 1);
        start_run();
        wait_done();

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fa_bist_checker.md
# fa_bist_checker

Synthesizable built-in self-test controller for the 1-bit full adder (`fa_using_ha`). It drives all eight `{a, b, cin}` vectors in ascending order, holding each for a programmable number of cycles. On the last cycle of each hold it samples the adder's `sum` and `c_out` and compares them against a golden model. At the end it reports an error count, the first failing vector and a pass/fail flag, so the adder can be checked in silicon or FPGA without a simulation bench.

## Interface
- `HOLD_CYCLES`, default 50: cycles each vector is held; legal range ≥ 2.
- `ERR_W`, default 4: width of the error counter.
- `clk`  in  1  system clock, rising-edge active.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin a run.
- `sum_in`  in  1  DUT `sum` output.
- `c_out_in`  in  1  DUT `c_out` output.
- `a_out`, `b_out`, `cin_out`  out  1 each  stimulus to the DUT; `{a_out, b_out, cin_out}` is the vector index.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  high from run completion until the next start or reset.
- `pass`  out  1  valid while `done` is high; 1 means no mismatches.
- `err_cnt`  out  `ERR_W`  mismatch count, saturating.
- `first_fail`  out  3  vector index of the first mismatch.
- `fail_valid`  out  1  `first_fail` holds a captured value.

## Operation
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1.
  - DONE: `busy`=0, `done`=1.
- Registers:
  - `vec[2:0]` drives `{a_out, b_out, cin_out}`; all outputs are registered.
  - `hold_cnt` counts 0..`HOLD_CYCLES`-1.
- IDLE → RUN on `start`=1. On that edge: `vec`=0, `hold_cnt`=0, and `err_cnt`, `first_fail`, `fail_valid` and `pass` are all cleared.
- In RUN, `hold_cnt` increments every cycle. When `hold_cnt`==`HOLD_CYCLES`-1 (the sample cycle):
  - Expected values: `exp_sum` = a^b^cin; `exp_cout` = (a&b)|(a&cin)|(b&cin), computed from the current `vec`.
  - A mismatch occurs when `sum_in`≠`exp_sum` or `c_out_in`≠`exp_cout`. One mismatch adds 1 to `err_cnt`, even if both bits are wrong.
  - `err_cnt` saturates at 2^`ERR_W`-1 and never wraps.
  - On the first mismatch of the run, `first_fail`=`vec` and `fail_valid`=1. Later mismatches do not overwrite them.
  - If `vec`≠7: `vec`++ and `hold_cnt`=0.
  - If `vec`==7: go to DONE, with `pass` = (no mismatch in the whole run, including this sample).
- DONE:
  - Stimulus outputs return to 0.
  - Results hold until `start`=1, which behaves exactly like IDLE → RUN (restart with cleared results).
- `start` is ignored while in RUN.
- The `sum_in` and `c_out_in` inputs are sampled only on sample cycles. The DUT may be combinational; the `HOLD_CYCLES`-1 cycles before the sample give it time to settle.

## Timing
- Reset (asynchronous, effective immediately; release is synchronized by the design flow): state=IDLE.
  - All outputs are 0: `a_out`, `b_out`, `cin_out`, `busy`, `done`, `pass`, `err_cnt`, `first_fail`, `fail_valid`.
  - `hold_cnt`=0.
- Reset asserted in the middle of a run aborts it. No partial results are retained.
- Edge E0 samples `start`. After E0: `busy`=1 and vector 0 is on the outputs.
- Vector v is presented in cycles E0+v·`HOLD_CYCLES` through E0+(v+1)·`HOLD_CYCLES`-1.
- Vector v is compared on the edge ending its last cycle. `err_cnt` and `first_fail` are updated right after that edge.
- After edge E0+8·`HOLD_CYCLES`: `busy`=0, `done`=1 and `pass` is valid.
  - `busy` is high for exactly 8·`HOLD_CYCLES` cycles.
  - `done` and `pass` become valid together in the same cycle.
- Restart from DONE: the `start` edge clears `done` and `pass`, sets `busy`=1 and drives vector 0. This is the same timing as from IDLE.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → all outputs are 0 immediately, asynchronously, without waiting for a clock edge.
- **Correct DUT:** `HOLD_CYCLES`=4, correct combinational full-adder model, one `start` pulse → `busy` high for 32 cycles; vectors 0..7 step every 4 cycles; then `done`=1, `pass`=1, `err_cnt`=0, `fail_valid`=0.
- **Stuck-at-0 sum:** force `sum_in` stuck at 0 → mismatches at vectors 1, 2, 4 and 7; `err_cnt`=4, `first_fail`=1, `fail_valid`=1, `pass`=0.
- **Inverted carry with saturation:** `ERR_W`=3 and `c_out_in` inverted → 8 mismatches; `err_cnt` saturates at 7; `first_fail`=0; `pass`=0.
- **Start during a run, then reset mid-run:** pulse `start` at vector 3 → ignored, and total busy time is still 32 cycles. Then drop `rst_n` during vector 5 → back to IDLE with all outputs 0. A new `start` then completes normally with `pass`=1.
- **Restart from DONE:** after a failing run, swap in a correct DUT and assert `start` → `err_cnt`, `fail_valid` and `done` clear on the start edge; the run ends with `pass`=1, `err_cnt`=0.
